// File: rtl/map_port_arbiter.sv
// Round-robin arbiter sharing the tile-map BRAM port among NUM_REQ requesters,
// with bounded locked bursts and a 2-stage tagged read-response pipeline.
module map_port_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_ROW   = 11,
  parameter int unsigned NUM_COL   = 19,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned DEPTH      = NUM_ROW * NUM_COL,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  lock,
  input  logic [NUM_REQ-1:0]                  we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_REQ-1:0][1:0]             wdata,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic                                mem_we,
  output logic [1:0]                          mem_wdata,
  input  logic [1:0]                          mem_rdata,
  output logic                                rvalid,
  output logic [ID_W-1:0]                     rid,
  output logic [1:0]                          rdata
);

  localparam int unsigned BCNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i, input int unsigned k);
    int unsigned s;
    s = (32'(i) + k) % NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic              owner_valid_q, owner_valid_d;
  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic              owner_hold;
  logic [ID_W-1:0]   base;
  logic [ID_W-1:0]   sel;
  logic              found;
  logic              accept;
  logic              sel_oor;
  logic              keep_lock;

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [1:0]            mem_wdata_q, mem_wdata_d;
  logic                  v1_q, v1_d, v2_q;
  logic [ID_W-1:0]       id1_q, id1_d, id2_q;
  logic                  oor1_q, oor1_d, oor2_q;

  // Grant selection: a live owner wins, otherwise scan from base.
  always_comb begin
    owner_hold = owner_valid_q && req[owner_q];
    base       = ptr_q;
    if (owner_valid_q && !owner_hold) begin
      base = wrap_inc(owner_q, 1);
    end
    sel   = '0;
    found = 1'b0;
    if (owner_hold) begin
      sel   = owner_q;
      found = 1'b1;
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (!found && req[wrap_inc(base, k)]) begin
          sel   = wrap_inc(base, k);
          found = 1'b1;
        end
      end
    end
    gnt = '0;
    if (found && !rst) begin
      gnt[sel] = 1'b1;
    end
  end

  assign accept  = |gnt;
  assign sel_oor = {1'b0, addr[sel]} >= DEPTH_EXT;
  // Ownership continues only while the locked run stays below MAX_BURST grants.
  assign keep_lock = owner_hold ? (32'(burst_cnt_q) + 2 < MAX_BURST) : (MAX_BURST > 1);

  always_comb begin
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    burst_cnt_d   = burst_cnt_q;
    if (owner_valid_q && !owner_hold) begin
      owner_valid_d = 1'b0;
      burst_cnt_d   = '0;
      ptr_d         = base;
    end
    if (accept) begin
      if (lock[sel] && keep_lock) begin
        owner_d       = sel;
        owner_valid_d = 1'b1;
        burst_cnt_d   = owner_hold ? burst_cnt_q + BCNT_W'(1) : '0;
        ptr_d         = base;
      end else begin
        owner_valid_d = 1'b0;
        burst_cnt_d   = '0;
        ptr_d         = wrap_inc(sel, 1);
      end
    end
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    v1_d        = 1'b0;
    id1_d       = id1_q;
    oor1_d      = 1'b0;
    if (accept) begin
      mem_addr_d  = sel_oor ? '0 : addr[sel];
      mem_we_d    = we[sel] && !sel_oor;
      mem_wdata_d = wdata[sel];
      v1_d        = !we[sel];
      id1_d       = sel;
      oor1_d      = sel_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      v1_q          <= 1'b0;
      id1_q         <= '0;
      oor1_q        <= 1'b0;
      v2_q          <= 1'b0;
      id2_q         <= '0;
      oor2_q        <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      v1_q          <= v1_d;
      id1_q         <= id1_d;
      oor1_q        <= oor1_d;
      v2_q          <= v1_q;
      id2_q         <= id1_q;
      oor2_q        <= oor1_q;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid    = v2_q;
  assign rid       = id2_q;
  // Out-of-range reads come back as solid wall.
  assign rdata     = v2_q ? (oor2_q ? 2'b11 : mem_rdata) : 2'b00;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter with a synchronous-read BRAM model.
module tb_map_port_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned ADDR_WIDTH = 8;

  logic                                clk;
  logic                                rst;
  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ-1:0]                  lock;
  logic [NUM_REQ-1:0]                  we;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr;
  logic [NUM_REQ-1:0][1:0]             wdata;
  logic [NUM_REQ-1:0]                  gnt;
  logic [ADDR_WIDTH-1:0]               mem_addr;
  logic                                mem_we;
  logic [1:0]                          mem_wdata;
  logic [1:0]                          mem_rdata;
  logic                                rvalid;
  logic [1:0]                          rid;
  logic [1:0]                          rdata;

  int n_cmp;
  int n_bad;
  int we_pulses;

  map_port_arbiter #(
    .NUM_REQ   (4),
    .NUM_ROW   (11),
    .NUM_COL   (19),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rvalid    (rvalid),
    .rid       (rid),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: preloaded on the first edge, write then synchronous read.
  logic [1:0] bram [256];
  logic       bram_init = 1'b0;
  always @(posedge clk) begin
    if (!bram_init) begin
      for (int i = 0; i < 256; i++) bram[i] <= 2'b00;
      bram[20]  <= 2'b01;
      bram[5]   <= 2'b10;
      bram[6]   <= 2'b11;
      bram[7]   <= 2'b01;
      bram[8]   <= 2'b10;
      bram_init <= 1'b1;
    end else if (mem_we) begin
      bram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= bram_init ? bram[mem_addr] : 2'b00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         rr_seq [8]   = '{2, 3, 0, 1, 2, 3, 0, 1};
  logic [1:0] rr_data [4]  = '{2'b10, 2'b11, 2'b01, 2'b10};
  logic [3:0] b_req [10]   = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                               4'b0110, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
  logic [3:0] b_gnt [10]   = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001,
                               4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
  logic       b_mwe [10]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    we_pulses = 0;
    rst   = 1'b1;
    req   = 4'hF;
    lock  = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;

    // Reset: requests ignored, registered outputs cleared.
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    step();
    step();
    rst = 1'b0;
    req = '0;
    #1;
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rid", 32'(rid), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    step();

    // Single read of address 20 by requester 1.
    req     = 4'b0010;
    addr[1] = 8'd20;
    #1;
    check("rd1_gnt", 32'(gnt), 32'b0010);
    step();
    req = '0;
    #1;
    check("rd1_mem_addr", 32'(mem_addr), 32'd20);
    check("rd1_mem_we", 32'(mem_we), 32'h0);
    check("rd1_rvalid_early", 32'(rvalid), 32'h0);
    step();
    #1;
    check("rd1_rvalid", 32'(rvalid), 32'h1);
    check("rd1_rid", 32'(rid), 32'h1);
    check("rd1_rdata", 32'(rdata), 32'b01);
    step();

    // Continuous reads from all four; pointer sits at 2 after the single read.
    for (int i = 0; i < 4; i++) addr[i] = ADDR_WIDTH'(5 + i);
    for (int c = 0; c < 10; c++) begin
      req = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) check("rr_gnt", 32'(gnt), 32'(4'b0001 << rr_seq[c]));
      else       check("rr_gnt_idle", 32'(gnt), 32'h0);
      if (c >= 2) begin
        check("rr_rvalid", 32'(rvalid), 32'h1);
        check("rr_rid", 32'(rid), 32'(rr_seq[c-2]));
        check("rr_rdata", 32'(rdata), 32'(rr_data[rr_seq[c-2]]));
      end
      step();
    end

    // Locked write burst by requester 2 competing with reads from 0 and 1.
    we       = 4'b0100;
    lock     = 4'b0100;
    addr[0]  = 8'd20;
    addr[1]  = 8'd20;
    addr[2]  = 8'd40;
    wdata[2] = 2'b10;
    for (int k = 0; k < 10; k++) begin
      req = b_req[k];
      #1;
      check("burst_gnt", 32'(gnt), 32'(b_gnt[k]));
      check("burst_mem_we", 32'(mem_we), 32'(b_mwe[k]));
      if (mem_we) we_pulses++;
      if (k == 1) begin
        check("burst_mem_addr", 32'(mem_addr), 32'd40);
        check("burst_mem_wdata", 32'(mem_wdata), 32'b10);
      end
      if (k == 6 || k == 7) begin
        check("burst_rvalid", 32'(rvalid), 32'h1);
        check("burst_rid", 32'(rid), (k == 6) ? 32'd0 : 32'd1);
        check("burst_rdata", 32'(rdata), 32'b01);
      end else begin
        check("burst_rvalid_idle", 32'(rvalid), 32'h0);
      end
      step();
    end
    check("burst_we_pulses", 32'(we_pulses), 32'd6);
    lock = '0;

    // Write then read of the same tile on consecutive accepts.
    we       = 4'b0100;
    wdata[2] = 2'b00;
    addr[3]  = 8'd40;
    req      = 4'b0100;
    #1;
    check("raw_wr_gnt", 32'(gnt), 32'b0100);
    step();
    we  = 4'b0000;
    req = 4'b1000;
    #1;
    check("raw_rd_gnt", 32'(gnt), 32'b1000);
    check("raw_mem_we", 32'(mem_we), 32'h1);
    check("raw_mem_wdata", 32'(mem_wdata), 32'b00);
    step();
    req = '0;
    #1;
    check("raw_mem_addr", 32'(mem_addr), 32'd40);
    step();
    #1;
    check("raw_rvalid", 32'(rvalid), 32'h1);
    check("raw_rid", 32'(rid), 32'd3);
    check("raw_rdata", 32'(rdata), 32'b00);
    step();

    // Out-of-range read then out-of-range write.
    addr[0] = 8'd209;
    req     = 4'b0001;
    #1;
    check("oor_rd_gnt", 32'(gnt), 32'b0001);
    step();
    we       = 4'b0010;
    addr[1]  = 8'd250;
    wdata[1] = 2'b01;
    req      = 4'b0010;
    #1;
    check("oor_wr_gnt", 32'(gnt), 32'b0010);
    check("oor_rd_mem_addr", 32'(mem_addr), 32'h0);
    check("oor_rd_mem_we", 32'(mem_we), 32'h0);
    step();
    req = '0;
    we  = '0;
    #1;
    check("oor_wr_mem_we", 32'(mem_we), 32'h0);
    check("oor_rd_rvalid", 32'(rvalid), 32'h1);
    check("oor_rd_rid", 32'(rid), 32'd0);
    check("oor_rd_rdata", 32'(rdata), 32'b11);
    step();
    #1;
    check("oor_wr_no_resp", 32'(rvalid), 32'h0);
    step();

    // Reset with two reads in flight.
    addr[0] = 8'd20;
    addr[1] = 8'd5;
    req     = 4'b0001;
    #1;
    check("mid_gnt0", 32'(gnt), 32'b0001);
    step();
    req = 4'b0010;
    #1;
    check("mid_gnt1", 32'(gnt), 32'b0010);
    step();
    rst = 1'b1;
    req = 4'hF;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rvalid_pre", 32'(rvalid), 32'h1);
    check("mid_rdata_pre", 32'(rdata), 32'b01);
    step();
    rst = 1'b0;
    req = '0;
    #1;
    check("mid_rvalid", 32'(rvalid), 32'h0);
    check("mid_rid", 32'(rid), 32'h0);
    check("mid_rdata", 32'(rdata), 32'h0);
    check("mid_mem_addr", 32'(mem_addr), 32'h0);
    check("mid_mem_we", 32'(mem_we), 32'h0);
    check("mid_mem_wdata", 32'(mem_wdata), 32'h0);
    step();
    req = 4'b1010;
    #1;
    check("mid_rvalid_late", 32'(rvalid), 32'h0);
    check("mid_ptr_reset_gnt", 32'(gnt), 32'b0010);
    step();
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
